// File: rtl/ysyx_23060124_key_lut_cam.sv
// Small key->data lookup table with priority match and a single-entry response register.
// Optional hit/miss statistics counters are enabled by defining YSYX_23060124_KEY_LUT_STATS_EN.
module ysyx_23060124_key_lut_cam #(
   parameter int NR_KEY      = 4,
   parameter int KEY_LEN     = 8,
   parameter int DATA_LEN    = 32,
   parameter int HAS_DEFAULT = 0,
   localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                wr_set,
   input  logic                flush,
   input  logic                lk_valid,
   output logic                lk_ready,
   input  logic [KEY_LEN-1:0]  lk_key,
   input  logic [DATA_LEN-1:0] default_out,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_LEN-1:0] rsp_data,
   output logic                rsp_hit,
   output logic [IDX_W-1:0]    rsp_idx
`ifdef YSYX_23060124_KEY_LUT_STATS_EN
  ,output logic [31:0]         hit_cnt
  ,output logic [31:0]         miss_cnt
`endif
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [31:0] NR_KEY_U = 32'(NR_KEY);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [NR_KEY-1:0]   vld_r;
   logic [KEY_LEN-1:0]  key_r  [NR_KEY];
   logic [DATA_LEN-1:0] data_r [NR_KEY];

   logic [NR_KEY-1:0]   match_s;
   logic                hit_s;
   logic [IDX_W-1:0]    hit_idx_s;
   logic [DATA_LEN-1:0] hit_data_s;
   logic [DATA_LEN-1:0] miss_data_s;
   logic                accept_s;
   logic                wr_ok_s;

   logic [DATA_LEN-1:0] rsp_data_r;
   logic                rsp_hit_r;
   logic [IDX_W-1:0]    rsp_idx_r;

   assign lk_ready    = (state_r == ST_EMPTY) || rsp_ready;
   assign accept_s    = lk_valid && lk_ready;
   assign wr_ok_s     = (32'(wr_idx) < NR_KEY_U);
   assign miss_data_s = (HAS_DEFAULT != 0) ? default_out : {DATA_LEN{1'b0}};

   assign rsp_valid = (state_r == ST_FULL);
   assign rsp_data  = rsp_data_r;
   assign rsp_hit   = rsp_hit_r;
   assign rsp_idx   = rsp_idx_r;

   // Priority match: scanning downward lets the lowest matching index win.
   always_comb begin
      match_s    = {NR_KEY{1'b0}};
      hit_idx_s  = {IDX_W{1'b0}};
      hit_data_s = {DATA_LEN{1'b0}};
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         match_s[i] = vld_r[i] && (key_r[i] == lk_key);
         hit_idx_s  = match_s[i] ? IDX_W'(i) : hit_idx_s;
         hit_data_s = match_s[i] ? data_r[i] : hit_data_s;
      end
      hit_s = |match_s;
   end

   // Output register occupancy: next state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_nxt_s = ST_FULL;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (rsp_ready && !accept_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // Key/data storage is intentionally not reset; vld_r alone decides visibility.
   always_ff @(posedge clock) begin
      if (!reset && !flush && wr_en && wr_ok_s && wr_set) begin
         key_r[wr_idx]  <= wr_key;
         data_r[wr_idx] <= wr_data;
      end
   end

   // Valid bits, FSM state and the response register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_EMPTY;
         vld_r      <= {NR_KEY{1'b0}};
         rsp_data_r <= {DATA_LEN{1'b0}};
         rsp_hit_r  <= 1'b0;
         rsp_idx_r  <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            rsp_hit_r  <= hit_s;
            rsp_idx_r  <= hit_s ? hit_idx_s : {IDX_W{1'b0}};
            rsp_data_r <= hit_s ? hit_data_s : miss_data_s;
         end
         if (flush) begin
            vld_r <= {NR_KEY{1'b0}};
         end else if (wr_en && wr_ok_s) begin
            vld_r[wr_idx] <= wr_set;
         end
      end
   end

`ifdef YSYX_23060124_KEY_LUT_STATS_EN
   logic [31:0] hit_cnt_r;
   logic [31:0] miss_cnt_r;

   assign hit_cnt  = hit_cnt_r;
   assign miss_cnt = miss_cnt_r;

   // Saturating per-lookup statistics; flush leaves them alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_cnt_r  <= 32'd0;
         miss_cnt_r <= 32'd0;
      end else if (accept_s) begin
         if (hit_s) begin
            hit_cnt_r <= (hit_cnt_r == 32'hFFFF_FFFF) ? hit_cnt_r : hit_cnt_r + 32'd1;
         end else begin
            miss_cnt_r <= (miss_cnt_r == 32'hFFFF_FFFF) ? miss_cnt_r : miss_cnt_r + 32'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ysyx_23060124_key_lut_cam.sv
// Scoreboard bench for ysyx_23060124_key_lut_cam: a table model predicts each accepted
// lookup's response, a monitor compares it whenever the response handshake completes.
module tb_ysyx_23060124_key_lut_cam;

   localparam int NK = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_idx;
   logic [7:0]  wr_key;
   logic [31:0] wr_data;
   logic        wr_set;
   logic        flush;
   logic        lk_valid;
   logic        lk_ready;
   logic [7:0]  lk_key;
   logic [31:0] default_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_hit;
   logic [1:0]  rsp_idx;
`ifdef YSYX_23060124_KEY_LUT_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   ysyx_23060124_key_lut_cam #(
      .NR_KEY(NK), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1)
   ) dut (
      .clock(clock), .reset(reset),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
      .wr_set(wr_set), .flush(flush),
      .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key), .default_out(default_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
`ifdef YSYX_23060124_KEY_LUT_STATS_EN
     ,.hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        hit;
      logic [1:0]  idx;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   logic        m_vld  [NK];
   logic [7:0]  m_key  [NK];
   logic [31:0] m_data [NK];
   logic        m_full;
   logic [31:0] m_hits;
   logic [31:0] m_miss;

   // One clock cycle: drive inputs, predict at the falling edge, advance past the rising edge.
   task automatic step(input logic rst, input logic lv, input logic [7:0] lk, input logic rr,
                       input logic we, input logic [1:0] wi, input logic [7:0] wk,
                       input logic [31:0] wd, input logic ws, input logic fl);
      exp_t e;
      int   found;
      reset = rst; lk_valid = lv; lk_key = lk; rsp_ready = rr;
      wr_en = we; wr_idx = wi; wr_key = wk; wr_data = wd; wr_set = ws; flush = fl;
      @(negedge clock);
      checks++;
      if (lk_ready !== (!m_full || rr)) begin
         errors++;
         $display("FAIL lk_ready got %0b want %0b at %0t", lk_ready, !m_full || rr, $time);
      end
      checks++;
      if (rsp_valid !== m_full) begin
         errors++;
         $display("FAIL rsp_valid got %0b want %0b at %0t", rsp_valid, m_full, $time);
      end
`ifdef YSYX_23060124_KEY_LUT_STATS_EN
      checks++;
      if (hit_cnt !== m_hits || miss_cnt !== m_miss) begin
         errors++;
         $display("FAIL stats got hit=%0d miss=%0d want hit=%0d miss=%0d",
                  hit_cnt, miss_cnt, m_hits, m_miss);
      end
`endif
      if (rst) begin
         for (int i = 0; i < NK; i++) m_vld[i] = 1'b0;
         m_full = 1'b0;
         m_hits = 32'd0;
         m_miss = 32'd0;
         exp_q.delete();
      end else begin
         if (lv && (!m_full || rr)) begin
            found = -1;
            for (int i = 0; i < NK; i++)
               if (found < 0 && m_vld[i] && m_key[i] == lk) found = i;
            e.hit  = (found >= 0);
            e.idx  = (found >= 0) ? 2'(found) : 2'd0;
            e.data = (found >= 0) ? m_data[found] : default_out;
            exp_q.push_back(e);
            if (found >= 0) m_hits = m_hits + 32'd1;
            else            m_miss = m_miss + 32'd1;
            m_full = 1'b1;
         end else if (rr) begin
            m_full = 1'b0;
         end
         if (fl) begin
            for (int i = 0; i < NK; i++) m_vld[i] = 1'b0;
         end else if (we) begin
            m_vld[wi] = ws;
            if (ws) begin
               m_key[wi]  = wk;
               m_data[wi] = wd;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic lookup(input logic [7:0] k);
      step(1'b0, 1'b1, k, 1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic write(input logic [1:0] i, input logic [7:0] k, input logic [31:0] d, input logic s);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, i, k, d, s, 1'b0);
   endtask

   exp_t held_v;
   logic held = 1'b0;

   // Monitor: pop and compare on each completed response handshake; check hold while stalled.
   always @(negedge clock) begin
      exp_t e;
      if (reset === 1'b1) begin
         held = 1'b0;
      end else begin
         if (held && rsp_valid === 1'b1) begin
            checks++;
            if ({rsp_hit, rsp_idx, rsp_data} !== held_v) begin
               errors++;
               $display("FAIL hold got %0b/%0d/%h want %0b/%0d/%h", rsp_hit, rsp_idx, rsp_data,
                        held_v.hit, held_v.idx, held_v.data);
            end
         end
         if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rsp at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               if (rsp_hit !== e.hit || rsp_idx !== e.idx || rsp_data !== e.data) begin
                  errors++;
                  $display("FAIL rsp got hit=%0b idx=%0d data=%h want hit=%0b idx=%0d data=%h at %0t",
                           rsp_hit, rsp_idx, rsp_data, e.hit, e.idx, e.data, $time);
               end
            end
         end
         held   = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
         held_v = {rsp_hit, rsp_idx, rsp_data};
      end
   end

   initial begin
      reset = 1'b1; lk_valid = 1'b0; lk_key = 8'h00; rsp_ready = 1'b1; wr_en = 1'b0;
      wr_idx = 2'd0; wr_key = 8'h00; wr_data = 32'h0; wr_set = 1'b0; flush = 1'b0;
      default_out = 32'h0000_DEAD;
      for (int i = 0; i < NK; i++) begin
         m_vld[i] = 1'b0; m_key[i] = 8'h00; m_data[i] = 32'h0;
      end
      m_full = 1'b0; m_hits = 32'd0; m_miss = 32'd0;
      repeat (2) @(posedge clock);
      #1;

      // Miss right after reset returns the default value.
      lookup(8'h00);
      idle();

      // Lowest matching index wins; invalidation exposes the next match.
      write(2'd1, 8'h12, 32'h0000_AAAA, 1'b1);
      write(2'd3, 8'h12, 32'h0000_BBBB, 1'b1);
      lookup(8'h12);
      write(2'd1, 8'h00, 32'h0, 1'b0);
      lookup(8'h12);
      idle();

      // Backpressure: one accept, then held; then back-to-back.
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) lookup(8'h12);
      idle();

      // Flush beats a same-cycle write; a same-cycle write is not forwarded.
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 8'h34, 32'h1, 1'b1, 1'b1);
      lookup(8'h34);
      step(1'b0, 1'b1, 8'h34, 1'b1, 1'b1, 2'd0, 8'h34, 32'h1, 1'b1, 1'b0);
      lookup(8'h34);
      idle();

      // Reset with a pending response, then statistics across a flush.
      lookup(8'h34);
      step(1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 2'd0, 8'h34, 32'h1, 1'b1, 1'b1);
      lookup(8'h34);
      write(2'd0, 8'h34, 32'h1, 1'b1);
      lookup(8'h34);
      lookup(8'h34);
      lookup(8'h99);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h00, 32'h0, 1'b0, 1'b1);
      idle();
`ifdef YSYX_23060124_KEY_LUT_STATS_EN
      checks++;
      if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
         errors++;
         $display("FAIL stats_directed got hit=%0d miss=%0d want hit=2 miss=2", hit_cnt, miss_cnt);
      end
`endif

      // Randomized traffic over a small key space so hits are frequent.
      for (int n = 0; n < 600; n++) begin
         default_out = $urandom;
         step(($urandom % 64) == 0, ($urandom % 4) != 0, 8'($urandom_range(0, 7)),
              ($urandom % 4) != 0, ($urandom % 2) == 0, 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 7)), $urandom, ($urandom % 4) != 0, ($urandom % 16) == 0);
      end
      repeat (3) idle();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
